// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: requests opcode/immediate words, delivers them with strobes, handles branches.
// Optional fetch timeout fault enabled by defining FETCH_TIMEOUT_EN.
//
// state   | meaning
// REQ_OP  | request opcode word at pc (imem_req rises the cycle after entry if not already high)
// DLV_OP  | opcode word held in imem_data, waiting for stall low to strobe it
// REQ_IMM | request immediate word at pc
// DLV_IMM | immediate word held in imem_data, waiting for stall low to strobe it
// FAULT   | fetch timed out; everything idle until reset
module fetch_unit #(
   parameter int ADDR_WIDTH     = 8,
   parameter int INST_WIDTH     = 8,
   parameter int RESET_PC       = 0,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [INST_WIDTH-1:0] imem_rdata,
   input  logic                  imm_needed,
   input  logic                  stall,
   input  logic                  branch,
   input  logic [ADDR_WIDTH-1:0] branch_addr,
   output logic [INST_WIDTH-1:0] imem_data,
   output logic                  opcode_update,
   output logic                  imm_update,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  fault
);

   typedef enum logic [2:0] {
      REQ_OP  = 3'd0,
      DLV_OP  = 3'd1,
      REQ_IMM = 3'd2,
      DLV_IMM = 3'd3,
      FAULT   = 3'd4
   } state_t;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("fetch_unit: TIMEOUT_CYCLES must be at least 1");
   end

   state_t                state_q, state_n;
   logic [ADDR_WIDTH-1:0] pc_q, pc_n;
   logic                  req_q, req_n;
   logic [INST_WIDTH-1:0] data_q, data_n;
   logic                  op_strb_q, op_strb_n;
   logic                  imm_strb_q, imm_strb_n;
   logic                  imm_lat_q, imm_lat_n;
   logic                  br_pend_q, br_pend_n;
   logic [ADDR_WIDTH-1:0] br_tgt_q, br_tgt_n;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             fault_q, fault_n;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= REQ_OP;
         pc_q       <= ADDR_WIDTH'(RESET_PC);
         req_q      <= 1'b0;
         data_q     <= '0;
         op_strb_q  <= 1'b0;
         imm_strb_q <= 1'b0;
         imm_lat_q  <= 1'b0;
         br_pend_q  <= 1'b0;
         br_tgt_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
         cnt_q      <= CNT_LOAD;
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_n;
         pc_q       <= pc_n;
         req_q      <= req_n;
         data_q     <= data_n;
         op_strb_q  <= op_strb_n;
         imm_strb_q <= imm_strb_n;
         imm_lat_q  <= imm_lat_n;
         br_pend_q  <= br_pend_n;
         br_tgt_q   <= br_tgt_n;
`ifdef FETCH_TIMEOUT_EN
         cnt_q      <= cnt_n;
         fault_q    <= fault_n;
`endif
      end
   end

   always_comb begin
      state_n    = state_q;
      pc_n       = pc_q;
      req_n      = req_q;
      data_n     = data_q;
      op_strb_n  = 1'b0;
      imm_strb_n = 1'b0;
      imm_lat_n  = imm_lat_q;
      br_pend_n  = br_pend_q;
      br_tgt_n   = br_tgt_q;
`ifdef FETCH_TIMEOUT_EN
      fault_n    = fault_q;
      cnt_n      = req_q ? cnt_q : CNT_LOAD;
`endif

      case (state_q)
         REQ_OP, REQ_IMM: begin
            if (!req_q) begin
               // no request outstanding yet: a branch simply retargets the upcoming one
               req_n = 1'b1;
               if (branch) begin
                  pc_n    = branch_addr;
                  state_n = REQ_OP;
               end
            end else if (imem_ack) begin
               req_n = 1'b0;
               if (branch || br_pend_q) begin
                  pc_n      = branch ? branch_addr : br_tgt_q;
                  br_pend_n = 1'b0;
                  state_n   = REQ_OP;
               end else begin
                  data_n = imem_rdata;
                  pc_n   = pc_q + ADDR_WIDTH'(1);
                  if (state_q == REQ_OP) begin
                     imm_lat_n = imm_needed;
                     state_n   = DLV_OP;
                  end else begin
                     state_n   = DLV_IMM;
                  end
               end
            end else begin
               if (branch) begin
                  br_pend_n = 1'b1;
                  br_tgt_n  = branch_addr;
               end
`ifdef FETCH_TIMEOUT_EN
               if (cnt_q == '0) begin
                  state_n = FAULT;
                  req_n   = 1'b0;
                  fault_n = 1'b1;
               end else begin
                  cnt_n = cnt_q - CNT_W'(1);
               end
`endif
            end
         end

         DLV_OP, DLV_IMM: begin
            if (branch) begin
               pc_n    = branch_addr;
               req_n   = 1'b1;
               state_n = REQ_OP;
            end else if (!stall) begin
               req_n = 1'b1;
               if (state_q == DLV_OP) begin
                  op_strb_n = 1'b1;
                  state_n   = imm_lat_q ? REQ_IMM : REQ_OP;
               end else begin
                  imm_strb_n = 1'b1;
                  state_n    = REQ_OP;
               end
            end
         end

         FAULT: begin
            req_n = 1'b0;
         end

         default: begin
            state_n = REQ_OP;
            req_n   = 1'b0;
         end
      endcase
   end

   assign imem_req      = req_q;
   assign imem_addr     = pc_q;
   assign pc            = pc_q;
   assign imem_data     = data_q;
   assign opcode_update = op_strb_q;
   assign imm_update    = imm_strb_q;
`ifdef FETCH_TIMEOUT_EN
   assign fault         = fault_q;
`else
   assign fault         = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; timeout scenario adapts to FETCH_TIMEOUT_EN.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_ack;
   logic [7:0] imem_rdata;
   logic       imm_needed;
   logic       stall;
   logic       branch;
   logic [7:0] branch_addr;
   logic [7:0] imem_data;
   logic       opcode_update;
   logic       imm_update;
   logic [7:0] pc;
   logic       fault;

   int vecs = 0;
   int errs = 0;

   fetch_unit #(.ADDR_WIDTH(8), .INST_WIDTH(8), .RESET_PC(0), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imm_needed(imm_needed),
      .stall(stall), .branch(branch), .branch_addr(branch_addr),
      .imem_data(imem_data), .opcode_update(opcode_update), .imm_update(imm_update),
      .pc(pc), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; imm_needed = 1'b0;
      stall = 1'b0; branch = 1'b0; branch_addr = '0;
      #3;
      vecs++;
      if ({imem_req, opcode_update, imm_update, fault} !== 4'b0000 || pc !== 8'h00 || imem_data !== 8'h00) begin
         errs++;
         $display("FAIL reset_state: req=%b op=%b imm=%b fault=%b pc=%h data=%h, want all 0",
                  imem_req, opcode_update, imm_update, fault, pc, imem_data);
      end
      step(); step();
      rst_n = 1'b1;
      #1;
      vecs++;
      if (imem_req !== 1'b0) begin errs++; $display("FAIL req_before_edge: got %b want 0", imem_req); end
      step();
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
         errs++; $display("FAIL first_req: req=%b addr=%h want 1/00", imem_req, imem_addr);
      end
   endtask

   task automatic test_basic();
      imem_ack = 1'b1; imem_rdata = 8'h11;
      step();
      imem_ack = 1'b0;
      vecs++;
      if (imem_req !== 1'b0 || imem_data !== 8'h11 || pc !== 8'h01 || opcode_update !== 1'b0) begin
         errs++; $display("FAIL basic_ack0: req=%b data=%h pc=%h op=%b want 0/11/01/0", imem_req, imem_data, pc, opcode_update);
      end
      step();
      vecs++;
      if (opcode_update !== 1'b1 || imm_update !== 1'b0 || imem_data !== 8'h11 || imem_req !== 1'b1 || imem_addr !== 8'h01) begin
         errs++; $display("FAIL basic_strobe0: op=%b imm=%b data=%h req=%b addr=%h want 1/0/11/1/01",
                          opcode_update, imm_update, imem_data, imem_req, imem_addr);
      end
      imem_ack = 1'b1; imem_rdata = 8'h22;
      step();
      imem_ack = 1'b0;
      vecs++;
      if (opcode_update !== 1'b0 || imem_data !== 8'h22 || pc !== 8'h02) begin
         errs++; $display("FAIL basic_ack1: op=%b data=%h pc=%h want 0/22/02", opcode_update, imem_data, pc);
      end
      step();
      vecs++;
      if (opcode_update !== 1'b1 || imm_update !== 1'b0 || imem_data !== 8'h22 || imem_addr !== 8'h02) begin
         errs++; $display("FAIL basic_strobe1: op=%b imm=%b data=%h addr=%h want 1/0/22/02",
                          opcode_update, imm_update, imem_data, imem_addr);
      end
   endtask

   task automatic test_imm();
      do_reset();
      imem_ack = 1'b1; imem_rdata = 8'h30; imm_needed = 1'b1;
      step();
      imem_ack = 1'b0; imm_needed = 1'b0;
      step();
      vecs++;
      if (opcode_update !== 1'b1 || imm_update !== 1'b0 || imem_data !== 8'h30 || imem_addr !== 8'h01) begin
         errs++; $display("FAIL imm_opcode: op=%b imm=%b data=%h addr=%h want 1/0/30/01",
                          opcode_update, imm_update, imem_data, imem_addr);
      end
      imem_ack = 1'b1; imem_rdata = 8'h7F;
      step();
      imem_ack = 1'b0;
      vecs++;
      if (opcode_update !== 1'b0 || imm_update !== 1'b0 || pc !== 8'h02) begin
         errs++; $display("FAIL imm_ack: op=%b imm=%b pc=%h want 0/0/02", opcode_update, imm_update, pc);
      end
      step();
      vecs++;
      if (imm_update !== 1'b1 || opcode_update !== 1'b0 || imem_data !== 8'h7F || pc !== 8'h02) begin
         errs++; $display("FAIL imm_strobe: imm=%b op=%b data=%h pc=%h want 1/0/7f/02",
                          imm_update, opcode_update, imem_data, pc);
      end
   endtask

   task automatic test_stall();
      int bad = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (imem_req !== 1'b1 || imem_addr !== 8'h02) bad++;
      end
      vecs++;
      if (bad != 0) begin errs++; $display("FAIL stall_addr_hold: %0d unstable cycles, want 0", bad); end
      imem_ack = 1'b1; imem_rdata = 8'h55;
      step();
      imem_ack = 1'b0; stall = 1'b1;
      vecs++;
      if (imem_req !== 1'b0 || pc !== 8'h03 || imem_data !== 8'h55) begin
         errs++; $display("FAIL stall_ack: req=%b pc=%h data=%h want 0/03/55", imem_req, pc, imem_data);
      end
      bad = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         if (opcode_update !== 1'b0 || imm_update !== 1'b0 || pc !== 8'h03 || imem_data !== 8'h55 || imem_req !== 1'b0) bad++;
      end
      vecs++;
      if (bad != 0) begin errs++; $display("FAIL stall_hold: %0d bad cycles, want 0", bad); end
      stall = 1'b0;
      step();
      vecs++;
      if (opcode_update !== 1'b1 || imem_data !== 8'h55 || imem_addr !== 8'h03) begin
         errs++; $display("FAIL stall_release: op=%b data=%h addr=%h want 1/55/03", opcode_update, imem_data, imem_addr);
      end
      step();
      vecs++;
      if (opcode_update !== 1'b0 || imm_update !== 1'b0) begin
         errs++; $display("FAIL stall_single: op=%b imm=%b want 0/0", opcode_update, imm_update);
      end
   endtask

   task automatic test_branch();
      int strb = 0;
      branch = 1'b1; branch_addr = 8'h05;
      step();
      branch = 1'b0;
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h03) begin
         errs++; $display("FAIL br_hold_addr: req=%b addr=%h want 1/03", imem_req, imem_addr);
      end
      imem_ack = 1'b1; imem_rdata = 8'hEE;
      step();
      imem_ack = 1'b0;
      strb += opcode_update + imm_update;
      vecs++;
      if (imem_req !== 1'b0 || pc !== 8'h05 || imem_data !== 8'h55) begin
         errs++; $display("FAIL br_discard: req=%b pc=%h data=%h want 0/05/55", imem_req, pc, imem_data);
      end
      step();
      strb += opcode_update + imm_update;
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h05) begin
         errs++; $display("FAIL br_req05: req=%b addr=%h want 1/05", imem_req, imem_addr);
      end
      branch = 1'b1; branch_addr = 8'h20;
      step();
      branch_addr = 8'h40;
      step();
      branch = 1'b0;
      strb += opcode_update + imm_update;
      step();
      imem_ack = 1'b1; imem_rdata = 8'hAB;
      step();
      imem_ack = 1'b0;
      strb += opcode_update + imm_update;
      vecs++;
      if (pc !== 8'h40 || imem_data !== 8'h55 || imem_req !== 1'b0) begin
         errs++; $display("FAIL br_overwrite: pc=%h data=%h req=%b want 40/55/0", pc, imem_data, imem_req);
      end
      step();
      strb += opcode_update + imm_update;
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin
         errs++; $display("FAIL br_req40: req=%b addr=%h want 1/40", imem_req, imem_addr);
      end
      imem_ack = 1'b1; imem_rdata = 8'h99; branch = 1'b1; branch_addr = 8'h10;
      step();
      imem_ack = 1'b0; branch = 1'b0;
      strb += opcode_update + imm_update;
      vecs++;
      if (pc !== 8'h10 || imem_data !== 8'h55) begin
         errs++; $display("FAIL br_with_ack: pc=%h data=%h want 10/55", pc, imem_data);
      end
      step();
      imem_ack = 1'b1; imem_rdata = 8'h77;
      step();
      imem_ack = 1'b0; branch = 1'b1; branch_addr = 8'h60;
      step();
      branch = 1'b0;
      strb += opcode_update + imm_update;
      vecs++;
      if (pc !== 8'h60 || imem_req !== 1'b1) begin
         errs++; $display("FAIL br_in_dlv: pc=%h req=%b want 60/1", pc, imem_req);
      end
      step();
      strb += opcode_update + imm_update;
      vecs++;
      if (strb != 0) begin errs++; $display("FAIL br_no_strobe: %0d strobes seen, want 0", strb); end
   endtask

   task automatic test_wrap();
      imem_ack = 1'b1; imem_rdata = 8'h01; branch = 1'b1; branch_addr = 8'hFF;
      step();
      imem_ack = 1'b0; branch = 1'b0;
      step();
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== 8'hFF) begin
         errs++; $display("FAIL wrap_req_ff: req=%b addr=%h want 1/ff", imem_req, imem_addr);
      end
      imem_ack = 1'b1; imem_rdata = 8'h42;
      step();
      imem_ack = 1'b0;
      vecs++;
      if (pc !== 8'h00 || imem_data !== 8'h42) begin
         errs++; $display("FAIL wrap_pc: pc=%h data=%h want 00/42", pc, imem_data);
      end
      step();
      vecs++;
      if (opcode_update !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 8'h00) begin
         errs++; $display("FAIL wrap_next: op=%b req=%b addr=%h want 1/1/00", opcode_update, imem_req, imem_addr);
      end
   endtask

   task automatic test_timeout();
      int bad = 0;
      do_reset();
`ifdef FETCH_TIMEOUT_EN
      for (int i = 0; i < 15; i++) begin
         step();
         if (fault !== 1'b0 || imem_req !== 1'b1) bad++;
      end
      vecs++;
      if (bad != 0) begin errs++; $display("FAIL to_early: %0d early-fault cycles, want 0", bad); end
      step();
      vecs++;
      if (fault !== 1'b1 || imem_req !== 1'b0) begin
         errs++; $display("FAIL to_fault: fault=%b req=%b want 1/0", fault, imem_req);
      end
      imem_ack = 1'b1; imem_rdata = 8'h5A;
      step(); step();
      vecs++;
      if (fault !== 1'b1 || imem_req !== 1'b0 || opcode_update !== 1'b0 || imem_data !== 8'h00) begin
         errs++; $display("FAIL to_sticky: fault=%b req=%b op=%b data=%h want 1/0/0/00", fault, imem_req, opcode_update, imem_data);
      end
`else
      for (int i = 0; i < 40; i++) begin
         step();
         if (fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h00) bad++;
      end
      vecs++;
      if (bad != 0) begin errs++; $display("FAIL to_wait: %0d bad cycles, want 0", bad); end
      imem_ack = 1'b1; imem_rdata = 8'h5A;
      step();
`endif
      // reset mid-activity with ack held high across release
      rst_n = 1'b0;
      #1;
      vecs++;
      if (imem_req !== 1'b0 || fault !== 1'b0 || pc !== 8'h00) begin
         errs++; $display("FAIL to_async_rst: req=%b fault=%b pc=%h want 0/0/00", imem_req, fault, pc);
      end
      step();
      rst_n = 1'b1;
      step();
      imem_ack = 1'b0;
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00 || imem_data !== 8'h00 || fault !== 1'b0) begin
         errs++; $display("FAIL to_restart: req=%b addr=%h data=%h fault=%b want 1/00/00/0", imem_req, imem_addr, imem_data, fault);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_imm();
      test_stall();
      test_branch();
      test_wrap();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
